noc_arq_rr_arbiter: RTL and testbench
=====================================

NOC_ARQ_RR_ARBITER -- requirements
Module: noc_arq_rr_arbiter

Interface
REQ-001 Parameters SHALL be: NOC_HEADER_SIZE, NOC_PAYLOAD_SIZE, from noc_parameter.vh, NoC flit field widths; NUM_REQ, default 4, number of requesters (2..8).
REQ-002 One clock; reset is synchronous and active-high. Ports SHALL be:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous reset, active-high.
- req_wrreq_i  in  NUM_REQ  per-requester flit valid.
- req_header_i  in  NUM_REQ*NOC_HEADER_SIZE  headers, requester i at slice i.
- req_payload_i  in  NUM_REQ*NOC_PAYLOAD_SIZE  payloads, requester i at slice i.
- req_stall_o  out  NUM_REQ  per-requester stall.
- grant_o  out  NUM_REQ  one-hot owner (current winner or burst lock holder), else 0.
- wrreq_o  out  1  registered output flit valid.
- header_o  out  NOC_HEADER_SIZE  registered output header.
- payload_o  out  NOC_PAYLOAD_SIZE  registered output payload.
- stall_i  in  1  downstream stall.

Function
REQ-003 Transfer into the block SHALL occur from requester i iff req_wrreq_i[i]=1 and req_stall_o[i]=0 in the same cycle.
REQ-004 Output register free (F) SHALL be: wrreq_o=0 or stall_i=0.
REQ-005 Output SHALL be a one-entry register: an accepted flit appears on wrreq_o/header_o/payload_o on the next cycle; latency 1 cycle.
REQ-006 wrreq_o, header_o and payload_o SHALL hold stable while wrreq_o=1 and stall_i=1.
REQ-007 wrreq_o SHALL drop to 0 after a cycle with wrreq_o=1, stall_i=0 and no new acceptance.
REQ-008 FSM SHALL have two states, IDLE (packet boundary) and LOCK (burst in progress).
REQ-009 In IDLE, the winner SHALL be the first requesting index at or after rr_ptr, modulo NUM_REQ.
REQ-010 grant_o SHALL equal the winner one-hot in IDLE, and 0 when nothing is requesting.
REQ-011 In IDLE, req_stall_o[i] SHALL be 0 only for the winner and only when F=1; all other bits SHALL be 1.
REQ-012 Header MSB SHALL be the burst flag: 1 means more flits follow, 0 means last or only flit.
REQ-013 Accepting a flit with MSB=1 in IDLE SHALL latch owner=winner and move to LOCK.
REQ-014 Accepting a flit with MSB=0 SHALL keep or return the FSM to IDLE and set rr_ptr=(owner+1) mod NUM_REQ.
REQ-015 In LOCK, grant_o SHALL equal the owner one-hot.
REQ-016 In LOCK, req_stall_o[owner]=!F and every other bit SHALL be 1.
REQ-017 If the owner deasserts req_wrreq_i mid-burst, the lock SHALL be held indefinitely until its MSB=0 flit is accepted.
REQ-018 rr_ptr SHALL change only on acceptance of a last flit, never on single stall cycles.
REQ-019 Simultaneous drain and accept (wrreq_o=1, stall_i=0, new flit accepted) SHALL load the new flit with wrreq_o staying 1 and no bubble.
REQ-020 Inputs of unselected requesters SHALL have no effect on outputs or state.

Reset
REQ-021 On reset_i=1 at a clock edge, state SHALL be IDLE, rr_ptr=0, owner=0, wrreq_o=0, header_o=0, payload_o=0.
REQ-022 During reset_i=1, req_stall_o SHALL be all 1s and grant_o=0.
REQ-023 Reset mid-burst SHALL discard the lock and any buffered flit with no output; ARQ retransmission recovers.

Configuration
REQ-024 Macro NOC_ARQ_ARB_ACK_PRIO_EN SHALL select the IDLE-state winner policy.
REQ-025 With NOC_ARQ_ARB_ACK_PRIO_EN defined, requester 0 (ACK path) SHALL win every IDLE arbitration in which it requests, regardless of rr_ptr; other requesters follow REQ-009.
REQ-026 With NOC_ARQ_ARB_ACK_PRIO_EN defined, LOCK behaviour SHALL be unchanged: an ACK never preempts a burst.
REQ-027 Without NOC_ARQ_ARB_ACK_PRIO_EN, arbitration SHALL be pure round-robin per REQ-009, with no fixed priority.

Verification
REQ-028 NUM_REQ=4, all four issue one single-flit packet per cycle, stall_i=0, no macro -> wrreq_o carries the flits from requesters 0,1,2,3,0 in consecutive cycles starting 1 cycle after the first request.
REQ-029 Req1 sends a 3-flit burst (MSB 1,1,0) while req2 requests throughout -> grant_o=4'b0010 for 3 accepted flits, then 4'b0100; no req2 flit interleaves.
REQ-030 wrreq_o=1 with stall_i=1 held for 5 cycles -> header_o/payload_o unchanged and all req_stall_o=1; stall_i=0 -> next flit appears the following cycle.
REQ-031 Req3 holds LOCK, pauses req_wrreq_i for 4 cycles while req0 requests -> grant_o stays 4'b1000 and req0 remains stalled.
REQ-032 With NOC_ARQ_ARB_ACK_PRIO_EN, rr_ptr=2, req0 and req2 requesting in IDLE -> req0 granted.
REQ-033 reset_i pulsed during the 2nd flit of a burst -> next cycle wrreq_o=0 and FSM in IDLE with rr_ptr=0.

Source files
------------

// File: rtl/noc_arq_rr_arbiter.sv
// Round-robin NoC flit arbiter with burst lock and a one-entry registered output stage.
// Optional macro NOC_ARQ_ARB_ACK_PRIO_EN gives requester 0 (ACK path) fixed priority at packet boundaries.
module noc_arq_rr_arbiter #(
  parameter int NOC_HEADER_SIZE  = 8,
  parameter int NOC_PAYLOAD_SIZE = 16,
  parameter int NUM_REQ          = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_REQ-1:0]              req_wrreq_i,
  input  logic [NUM_REQ*NOC_HEADER_SIZE-1:0]  req_header_i,
  input  logic [NUM_REQ*NOC_PAYLOAD_SIZE-1:0] req_payload_i,
  output logic [NUM_REQ-1:0]              req_stall_o,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic                            wrreq_o,
  output logic [NOC_HEADER_SIZE-1:0]      header_o,
  output logic [NOC_PAYLOAD_SIZE-1:0]     payload_o,
  input  logic                            stall_i
);

  localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [PW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]               owner_q, owner_d;
  logic                        wrreq_q, wrreq_d;
  logic [NOC_HEADER_SIZE-1:0]  header_q, header_d;
  logic [NOC_PAYLOAD_SIZE-1:0] payload_q, payload_d;

  logic                        free_s;
  logic                        win_found_s;
  logic [PW-1:0]               win_idx_s;
  logic                        sel_valid_s;
  logic [PW-1:0]               sel_idx_s;
  logic [NOC_HEADER_SIZE-1:0]  sel_header_s;
  logic [NOC_PAYLOAD_SIZE-1:0] sel_payload_s;
  logic                        accept_s;
  logic                        burst_s;
  logic [NUM_REQ-1:0]          grant_s;
  logic [NUM_REQ-1:0]          stall_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == NUM_REQ - 1) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int          idx;
    res = {1'b0, ptr};
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!res[PW] && req[idx]) begin
        res = {1'b1, PW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign free_s = !wrreq_q || !stall_i;

  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = rr_ptr_q;
`ifdef NOC_ARQ_ARB_ACK_PRIO_EN
    if (req_wrreq_i[0]) begin
      {win_found_s, win_idx_s} = {1'b1, {PW{1'b0}}};
    end else begin
      {win_found_s, win_idx_s} = rr_pick(req_wrreq_i, rr_ptr_q);
    end
`else
    {win_found_s, win_idx_s} = rr_pick(req_wrreq_i, rr_ptr_q);
`endif
  end

  always_comb begin
    if (state_q == LOCK) begin
      sel_idx_s   = owner_q;
      sel_valid_s = req_wrreq_i[owner_q];
    end else begin
      sel_idx_s   = win_idx_s;
      sel_valid_s = win_found_s;
    end
    sel_header_s  = req_header_i[int'(sel_idx_s)*NOC_HEADER_SIZE +: NOC_HEADER_SIZE];
    sel_payload_s = req_payload_i[int'(sel_idx_s)*NOC_PAYLOAD_SIZE +: NOC_PAYLOAD_SIZE];
    accept_s      = sel_valid_s && free_s && !reset_i;
    burst_s       = sel_header_s[NOC_HEADER_SIZE-1];
  end

  // Owner stays granted through a paused burst; idle grant only follows a live request.
  always_comb begin
    grant_s = {NUM_REQ{1'b0}};
    stall_s = {NUM_REQ{1'b1}};
    if (reset_i) begin
      grant_s = {NUM_REQ{1'b0}};
    end else if (state_q == LOCK) begin
      grant_s[owner_q] = 1'b1;
      stall_s[owner_q] = !free_s;
    end else if (win_found_s) begin
      grant_s[win_idx_s] = 1'b1;
      stall_s[win_idx_s] = !free_s;
    end else begin
      grant_s = {NUM_REQ{1'b0}};
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    wrreq_d   = wrreq_q;
    header_d  = header_q;
    payload_d = payload_q;
    case (state_q)
      IDLE: begin
        if (accept_s && burst_s) begin
          state_d = LOCK;
        end else begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (accept_s && !burst_s) begin
          state_d = IDLE;
        end else begin
          state_d = LOCK;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept_s) begin
      owner_d   = sel_idx_s;
      wrreq_d   = 1'b1;
      header_d  = sel_header_s;
      payload_d = sel_payload_s;
      if (!burst_s) begin
        rr_ptr_d = ptr_inc(sel_idx_s);
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else if (free_s) begin
      wrreq_d = 1'b0;
    end else begin
      wrreq_d = wrreq_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= {PW{1'b0}};
      owner_q   <= {PW{1'b0}};
      wrreq_q   <= 1'b0;
      header_q  <= {NOC_HEADER_SIZE{1'b0}};
      payload_q <= {NOC_PAYLOAD_SIZE{1'b0}};
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      wrreq_q   <= wrreq_d;
      header_q  <= header_d;
      payload_q <= payload_d;
    end
  end

  assign grant_o     = grant_s;
  assign req_stall_o = stall_s;
  assign wrreq_o     = wrreq_q;
  assign header_o    = header_q;
  assign payload_o   = payload_q;

endmodule

// File: tb/tb_noc_arq_rr_arbiter.sv
// Directed self-checking bench for noc_arq_rr_arbiter (NUM_REQ=4, 8-bit header, 16-bit payload).
module tb_noc_arq_rr_arbiter;
  localparam int N = 4;
  localparam int H = 8;
  localparam int P = 16;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N-1:0]   req_wrreq;
  logic [N*H-1:0] req_header;
  logic [N*P-1:0] req_payload;
  logic [N-1:0]   req_stall;
  logic [N-1:0]   grant;
  logic           wrreq;
  logic [H-1:0]   header;
  logic [P-1:0]   payload;
  logic           stall_i;
  int             total = 0;
  int             bad = 0;

  always #5 clk = ~clk;

  noc_arq_rr_arbiter #(.NOC_HEADER_SIZE(H), .NOC_PAYLOAD_SIZE(P), .NUM_REQ(N)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_wrreq_i(req_wrreq), .req_header_i(req_header),
    .req_payload_i(req_payload), .req_stall_o(req_stall), .grant_o(grant), .wrreq_o(wrreq),
    .header_o(header), .payload_o(payload), .stall_i(stall_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [H-1:0] h, input logic [P-1:0] p);
    req_wrreq[i]          = v;
    req_header[i*H +: H]  = h;
    req_payload[i*P +: P] = p;
  endtask

  task automatic clear_reqs();
    req_wrreq   = '0;
    req_header  = '0;
    req_payload = '0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    stall_i = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'h80, 16'hFFFF);
    #2;
    total++; if (req_stall !== 4'hF) begin bad++; $display("FAIL reset_stall got=%b exp=%b", req_stall, 4'hF); end
    total++; if (grant !== 4'h0) begin bad++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'h0); end
    tick();
    total++; if (wrreq !== 1'b0) begin bad++; $display("FAIL reset_wrreq got=%b exp=0", wrreq); end
    total++; if (header !== 8'h00) begin bad++; $display("FAIL reset_header got=%h exp=00", header); end
    total++; if (payload !== 16'h0000) begin bad++; $display("FAIL reset_payload got=%h exp=0000", payload); end
    reset_i = 1'b0;
    clear_reqs();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(i), 16'h1000 + 16'(i));
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      #2;
      total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, grant, exp_g); end
      total++; if (req_stall !== ~exp_g) begin bad++; $display("FAIL rr_stall k=%0d got=%b exp=%b", k, req_stall, ~exp_g); end
      tick();
      total++; if (wrreq !== 1'b1) begin bad++; $display("FAIL rr_wrreq k=%0d got=%b exp=1", k, wrreq); end
      total++; if (header !== 8'(k % 4)) begin bad++; $display("FAIL rr_header k=%0d got=%h exp=%h", k, header, 8'(k % 4)); end
      total++; if (payload !== 16'h1000 + 16'(k % 4)) begin bad++; $display("FAIL rr_payload k=%0d got=%h", k, payload); end
    end
    clear_reqs();
    #2;
    tick();
    total++; if (wrreq !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b exp=0", wrreq); end
  endtask

  task automatic test_burst();
    logic [H-1:0] h;
    set_req(2, 1'b1, 8'h02, 16'h2200);
    for (int k = 0; k < 3; k++) begin
      h = (k < 2) ? 8'h81 : 8'h01;
      set_req(1, 1'b1, h, 16'h2100 + 16'(k));
      #2;
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL burst_grant k=%0d got=%b exp=0010", k, grant); end
      total++; if (req_stall !== 4'b1101) begin bad++; $display("FAIL burst_stall k=%0d got=%b exp=1101", k, req_stall); end
      tick();
      total++; if (header !== h) begin bad++; $display("FAIL burst_header k=%0d got=%h exp=%h", k, header, h); end
      total++; if (payload !== 16'h2100 + 16'(k)) begin bad++; $display("FAIL burst_payload k=%0d got=%h", k, payload); end
    end
    set_req(1, 1'b0, 8'h00, 16'h0000);
    #2;
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL burst_next_grant got=%b exp=0100", grant); end
    tick();
    total++; if (header !== 8'h02 || payload !== 16'h2200) begin bad++; $display("FAIL burst_next_flit got=%h/%h exp=02/2200", header, payload); end
    clear_reqs();
    #2;
    tick();
  endtask

  task automatic test_stall();
    set_req(3, 1'b1, 8'h03, 16'h3333);
    #2;
    tick();
    total++; if (wrreq !== 1'b1 || header !== 8'h03) begin bad++; $display("FAIL stall_first got=%b/%h exp=1/03", wrreq, header); end
    stall_i = 1'b1;
    set_req(3, 1'b1, 8'h03, 16'h4444);
    set_req(0, 1'b1, 8'h00, 16'h3000);
    for (int k = 0; k < 5; k++) begin
      #2;
      total++; if (req_stall !== 4'hF) begin bad++; $display("FAIL stall_req_stall k=%0d got=%b exp=1111", k, req_stall); end
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL stall_grant k=%0d got=%b exp=0001", k, grant); end
      tick();
      total++; if (wrreq !== 1'b1 || header !== 8'h03 || payload !== 16'h3333) begin
        bad++; $display("FAIL stall_hold k=%0d got=%b/%h/%h exp=1/03/3333", k, wrreq, header, payload);
      end
    end
    stall_i = 1'b0;
    #2;
    total++; if (req_stall !== 4'b1110) begin bad++; $display("FAIL stall_release got=%b exp=1110", req_stall); end
    tick();
    total++; if (wrreq !== 1'b1 || header !== 8'h00 || payload !== 16'h3000) begin
      bad++; $display("FAIL stall_no_bubble got=%b/%h/%h exp=1/00/3000", wrreq, header, payload);
    end
    clear_reqs();
    #2;
    tick();
    total++; if (wrreq !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", wrreq); end
  endtask

  task automatic test_lock_pause();
    set_req(3, 1'b1, 8'h83, 16'h5300);
    #2;
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL pause_first_grant got=%b exp=1000", grant); end
    tick();
    total++; if (header !== 8'h83) begin bad++; $display("FAIL pause_first_header got=%h exp=83", header); end
    set_req(3, 1'b0, 8'h00, 16'h0000);
    set_req(0, 1'b1, 8'h00, 16'h5000);
    for (int k = 0; k < 4; k++) begin
      #2;
      total++; if (grant !== 4'b1000) begin bad++; $display("FAIL pause_grant k=%0d got=%b exp=1000", k, grant); end
      total++; if (req_stall[0] !== 1'b1) begin bad++; $display("FAIL pause_req0_stall k=%0d got=%b exp=1", k, req_stall[0]); end
      tick();
      total++; if (wrreq !== 1'b0) begin bad++; $display("FAIL pause_wrreq k=%0d got=%b exp=0", k, wrreq); end
    end
    set_req(3, 1'b1, 8'h03, 16'h5301);
    #2;
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL pause_last_grant got=%b exp=1000", grant); end
    tick();
    total++; if (header !== 8'h03 || payload !== 16'h5301) begin bad++; $display("FAIL pause_last_flit got=%h/%h exp=03/5301", header, payload); end
    set_req(3, 1'b0, 8'h00, 16'h0000);
    #2;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL pause_after_grant got=%b exp=0001", grant); end
    tick();
    total++; if (header !== 8'h00 || payload !== 16'h5000) begin bad++; $display("FAIL pause_after_flit got=%h/%h exp=00/5000", header, payload); end
    clear_reqs();
    #2;
    tick();
  endtask

  task automatic test_arb_policy();
    logic [N-1:0] exp_g;
    logic [H-1:0] exp_h;
`ifdef NOC_ARQ_ARB_ACK_PRIO_EN
    exp_g = 4'b0001;
    exp_h = 8'h00;
`else
    exp_g = 4'b0100;
    exp_h = 8'h02;
`endif
    set_req(1, 1'b1, 8'h01, 16'h6100);
    #2;
    tick();
    clear_reqs();
    set_req(0, 1'b1, 8'h00, 16'h6000);
    set_req(2, 1'b1, 8'h02, 16'h6200);
    #2;
    total++; if (grant !== exp_g) begin bad++; $display("FAIL policy_grant got=%b exp=%b", grant, exp_g); end
    tick();
    total++; if (header !== exp_h) begin bad++; $display("FAIL policy_header got=%h exp=%h", header, exp_h); end
    clear_reqs();
    #2;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    set_req(1, 1'b1, 8'h81, 16'h7100);
    #2;
    tick();
    total++; if (wrreq !== 1'b1 || header !== 8'h81) begin bad++; $display("FAIL rstb_first got=%b/%h exp=1/81", wrreq, header); end
    reset_i = 1'b1;
    set_req(1, 1'b1, 8'h81, 16'h7101);
    #2;
    total++; if (req_stall !== 4'hF || grant !== 4'h0) begin bad++; $display("FAIL rstb_during got=%b/%b exp=1111/0000", req_stall, grant); end
    tick();
    total++; if (wrreq !== 1'b0 || header !== 8'h00) begin bad++; $display("FAIL rstb_out got=%b/%h exp=0/00", wrreq, header); end
    reset_i = 1'b0;
    set_req(0, 1'b1, 8'h00, 16'h7000);
    set_req(1, 1'b1, 8'h01, 16'h7102);
    #2;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rstb_idle_grant got=%b exp=0001", grant); end
    tick();
    total++; if (header !== 8'h00 || payload !== 16'h7000) begin bad++; $display("FAIL rstb_flit got=%h/%h exp=00/7000", header, payload); end
    clear_reqs();
    tick();
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_round_robin();
    test_burst();
    test_stall();
    test_lock_pause();
    test_arb_policy();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
